bin2bcd_seq: RTL and testbench
==============================

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 SHALL have parameter IN_W, default 8, binary input width.
REQ-002 SHALL have parameter NDIG, default 3, number of BCD digits produced; 10^NDIG > 2^IN_W - 1 is a legal-configuration constraint.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid  input  1  upstream offers in_bin.
REQ-006 SHALL have port in_ready  output  1  block can accept; high only in IDLE.
REQ-007 SHALL have port in_bin  input  IN_W  unsigned binary value.
REQ-008 SHALL have port out_valid  output  1  bcd holds a fresh result; high only in DONE.
REQ-009 SHALL have port out_ready  input  1  downstream consumes result.
REQ-010 SHALL have port bcd  output  4*NDIG  result, digit 0 (units) in [3:0], digit k in [4k+3:4k], each 0..9, feeding per-digit seven-segment decoders.

Function
REQ-011 SHALL implement FSM states IDLE, CONV, DONE.
REQ-012 SHALL accept input on a rising edge where in_valid && in_ready: latch in_bin into shift register, clear working BCD register, clear iteration counter, go IDLE->CONV.
REQ-013 SHALL ignore in_valid and hold in_bin unsampled while in CONV or DONE.
REQ-014 SHALL, per CONV cycle, add 3 to every working digit >= 5, then shift {working BCD, shift register} left by one, taking the shift register MSB into digit 0 LSB.
REQ-015 SHALL perform exactly IN_W iterations; on the edge completing iteration IN_W, copy working BCD into bcd and go CONV->DONE.
REQ-016 SHALL assert out_valid exactly IN_W cycles after the acceptance edge (first cycle in DONE).
REQ-017 SHALL hold out_valid and bcd stable in DONE until out_ready is high on a rising edge, then go DONE->IDLE.
REQ-018 SHALL keep bcd unchanged (previous result) throughout IDLE and CONV; bcd changes only on CONV->DONE.
REQ-019 SHALL NOT accept new input in the same cycle a result is consumed; minimum issue interval IN_W+2 cycles.
REQ-020 SHALL produce bcd digits only in 0..9; input 0 yields all-zero bcd, input 2^IN_W-1 yields its exact decimal value.
REQ-021 SHALL size the iteration counter to ceil(log2(IN_W+1)) bits with no wrap-around during a conversion.

Reset
REQ-022 SHALL on rst_n low, immediately and asynchronously: state IDLE, in_ready 1, out_valid 0, bcd 0, working registers 0, counter 0.
REQ-023 SHALL abort any in-progress conversion on reset; no partial result ever appears on bcd.
REQ-024 SHALL accept input on the first rising edge after rst_n deasserts if in_valid is high.

Structure
REQ-025 SHALL place the FSM state encoding, digit width constant (4), and add-3 threshold (5) in shared package bcd_pkg.
REQ-026 SHALL instantiate NDIG copies of sub-module bcd_add3 (4-bit in, 4-bit out, combinational conditional +3).
REQ-027 SHALL contain no combinational path from in_valid/in_bin to any output; in_ready and out_valid decode from state only.

Verification
REQ-028 SHALL cover: in_bin=0, out_ready=1 -> out_valid after 8 cycles, bcd=12'h000.
REQ-029 SHALL cover: in_bin=255 -> bcd=12'h255; in_bin=99 -> bcd=12'h099; in_bin=128 -> bcd=12'h128.
REQ-030 SHALL cover: out_ready held low 20 cycles after result -> out_valid and bcd stable, in_ready low, new in_valid ignored throughout.
REQ-031 SHALL cover: rst_n pulsed low at CONV iteration 4 of in_bin=200 -> out_valid 0, bcd 0 immediately; next conversion of 37 -> bcd=12'h037.
REQ-032 SHALL cover: back-to-back in_valid held high with values 1,2,3 -> results 001,002,003 in order, issue interval exactly 10 cycles.
REQ-033 SHALL cover: exhaustive sweep 0..255 with random out_ready stalls -> every result matches reference decimal, every digit <= 9.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared constants and FSM encoding for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DIGIT_W     = 4;
  localparam int ADD3_THRESH = 5;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit that would overflow past 9 after the next shift.
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = din;
    if (din >= 4'(ADD3_THRESH)) begin
      dout = din + 4'd3;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: one bit per cycle, IN_W cycles per conversion,
// result held on bcd from CONV->DONE until the next conversion completes.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int IN_W = 8,
  parameter int NDIG = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN_W-1:0]         in_bin,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DIGIT_W*NDIG-1:0] bcd
);

  localparam int BW    = DIGIT_W * NDIG;
  localparam int CNT_W = $clog2(IN_W + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(IN_W - 1);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // ready depends only on the registered state, so no input reaches an output combinationally.
  state_e            state_q, state_d;
  logic [IN_W-1:0]   shift_q, shift_d;
  logic [BW-1:0]     work_q, work_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BW-1:0]     adj;

  for (genvar g = 0; g < NDIG; g++) begin : g_digit
    bcd_add3 u_add3 (
      .din  (work_q[g*DIGIT_W +: DIGIT_W]),
      .dout (adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // The top digit never reaches 8 for a legal IN_W/NDIG pair, so its MSB is shifted out as zero.
  logic unused_adj_msb;
  assign unused_adj_msb = adj[BW-1];

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    work_d  = work_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          shift_d = in_bin;
          work_d  = '0;
          cnt_d   = '0;
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        work_d  = {adj[BW-2:0], shift_q[IN_W-1]};
        shift_d = shift_q << 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          bcd_d   = work_d;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      work_q  <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      work_q  <= work_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign bcd       = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq against a decimal-arithmetic reference model.
module tb_bin2bcd_seq;

  localparam int IN_W = 8;
  localparam int NDIG = 3;
  localparam int BW   = 4 * NDIG;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [IN_W-1:0] in_bin;
  logic            out_valid;
  logic            out_ready;
  logic [BW-1:0]   bcd;

  int total = 0;
  int bad   = 0;
  logic [BW-1:0] exp_q[$];

  bin2bcd_seq #(.IN_W(IN_W), .NDIG(NDIG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bin    (in_bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd       (bcd)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference: decimal digits by plain division
  function automatic logic [BW-1:0] ref_bcd(input int v);
    logic [BW-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int k = 0; k < NDIG; k++) begin
      r[4*k +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // driver: offer v, wait for out_valid; lat = edges from acceptance to out_valid
  task automatic send(input logic [IN_W-1:0] v, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1;
    in_bin   = v;
    @(negedge clk);
    in_valid = 1'b0;
    in_bin   = IN_W'($urandom);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume(input int stall);
    out_ready = 1'b0;
    repeat (stall) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; in_bin = '0; out_ready = 1'b0;
    #3;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || bcd !== '0) begin
      bad++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b bcd=%h, want 1 0 000", in_ready, out_valid, bcd);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [IN_W-1:0] vals[4];
    int lat;
    vals = '{8'd0, 8'd255, 8'd99, 8'd128};
    for (int i = 0; i < 4; i++) begin
      send(vals[i], lat);
      total++;
      if (lat !== IN_W) begin
        bad++;
        $display("FAIL directed_latency: in=%0d lat=%0d want %0d", vals[i], lat, IN_W);
      end
      total++;
      if (bcd !== ref_bcd(int'(vals[i]))) begin
        bad++;
        $display("FAIL directed_value: in=%0d bcd=%h want %h", vals[i], bcd, ref_bcd(int'(vals[i])));
      end
      consume(0);
    end
  endtask

  task automatic test_stall;
    logic [IN_W-1:0] v;
    logic [BW-1:0] e;
    int lat;
    v = IN_W'($urandom_range(100, 254));
    e = ref_bcd(int'(v));
    send(v, lat);
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1;
      in_bin   = IN_W'($urandom);
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || bcd !== e || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold: cyc=%0d out_valid=%b bcd=%h in_ready=%b want 1 %h 0", c, out_valid, bcd, in_ready, e);
      end
    end
    in_valid = 1'b0;
    consume(0);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || bcd !== e) begin
      bad++;
      $display("FAIL stall_release: in_ready=%b out_valid=%b bcd=%h want 1 0 %h", in_ready, out_valid, bcd, e);
    end
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || bcd !== e) begin
      bad++;
      $display("FAIL stall_idle_hold: in_ready=%b bcd=%h want 1 %h", in_ready, bcd, e);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    while (!in_ready) @(negedge clk);
    in_valid = 1'b1;
    in_bin   = 8'd200;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || bcd !== '0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_abort: out_valid=%b bcd=%h in_ready=%b want 0 000 1", out_valid, bcd, in_ready);
    end
    in_valid = 1'b1;
    in_bin   = 8'd37;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_first_accept: in_ready=%b want 0", in_ready);
    end
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat !== IN_W || bcd !== 12'h037) begin
      bad++;
      $display("FAIL reset_next_conv: lat=%0d bcd=%h want %0d 037", lat, bcd, IN_W);
    end
    consume(0);
  endtask

  task automatic test_back_to_back;
    logic [IN_W-1:0] vals[3];
    int acc_t[$];
    int idx, got, cyc;
    logic [BW-1:0] e;
    vals = '{8'd1, 8'd2, 8'd3};
    idx = 0; got = 0; cyc = 0;
    out_ready = 1'b1;
    while (got < 3 && cyc < 80) begin
      if (out_valid) begin
        e = exp_q.pop_front();
        total++;
        if (bcd !== e) begin
          bad++;
          $display("FAIL b2b_value: n=%0d bcd=%h want %h", got, bcd, e);
        end
        got++;
      end
      if (in_ready && idx < 3) begin
        in_valid = 1'b1;
        in_bin   = vals[idx];
        exp_q.push_back(ref_bcd(int'(vals[idx])));
        acc_t.push_back(cyc);
        idx++;
      end else if (idx == 3 && !in_ready) begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    total++;
    if (got !== 3 || acc_t.size() !== 3) begin
      bad++;
      $display("FAIL b2b_count: results=%0d accepts=%0d want 3 3", got, acc_t.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        total++;
        if (acc_t[i] - acc_t[i-1] !== IN_W + 2) begin
          bad++;
          $display("FAIL b2b_interval: gap=%0d want %0d", acc_t[i] - acc_t[i-1], IN_W + 2);
        end
      end
    end
    exp_q.delete();
  endtask

  task automatic test_sweep;
    int lat, n;
    logic [BW-1:0] e;
    logic digits_ok;
    for (int v = 0; v < 256; v++) begin
      exp_q.push_back(ref_bcd(v));
      send(IN_W'(v), lat);
      e = exp_q.pop_front();
      total++;
      if (lat !== IN_W || bcd !== e) begin
        bad++;
        $display("FAIL sweep_value: in=%0d lat=%0d bcd=%h want %0d %h", v, lat, bcd, IN_W, e);
      end
      digits_ok = 1'b1;
      for (int k = 0; k < NDIG; k++) if (bcd[4*k +: 4] > 4'd9) digits_ok = 1'b0;
      total++;
      if (digits_ok !== 1'b1) begin
        bad++;
        $display("FAIL sweep_digit_range: in=%0d bcd=%h", v, bcd);
      end
      n = 0;
      while (out_valid && n < 50) begin
        out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        n++;
        if (out_valid) begin
          total++;
          if (bcd !== e) begin
            bad++;
            $display("FAIL sweep_stall_hold: in=%0d bcd=%h want %h", v, bcd, e);
          end
        end
      end
      out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL sweep_consume_timeout: in=%0d out_valid=%b want 0", v, out_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
